mem_access_ctrl: RTL and testbench

Memory-access stage controller between the EX/MEM pipeline register and the word-wide data memory in the tp4 pipeline. It converts byte-addressed load/store requests of byte, halfword or word size into word accesses on the single-port synchronous RAM. The RAM either reads or writes in a given cycle, and read data arrives one cycle after the address. The block performs lane extraction with sign/zero extension for loads and read-modify-write for sub-word stores, stalling the pipeline as needed.

---
 rtl/mem_access_ctrl_pkg.sv | 30 +++
 rtl/mem_access_ctrl_if.sv | 31 +++
 rtl/mem_access_ctrl_byte_lane_unit.sv | 58 +++++
 rtl/mem_access_ctrl.sv | 110 +++++++++++
 tb/tb_mem_access_ctrl.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - size/state encodings and alignment helpers for the memory-access stage
// Shared by the controller, its lane unit and the bench.
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_WAIT = 2'd1,
      ST_RMW  = 2'd2
   } state_t;

   // Size 2'b11 behaves as a word everywhere.
   function automatic logic is_subword(input logic [1:0] size);
      return (size == SZ_BYTE) || (size == SZ_HALF);
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic r_bad;
      case (size)
         SZ_BYTE: r_bad = 1'b0;
         SZ_HALF: r_bad = lane[0];
         default: r_bad = (lane != 2'b00);
      endcase
      return r_bad;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - pipeline request and RAM port bundle for the memory-access stage
// master = pipeline plus RAM side, slave = the controller.
interface mem_access_ctrl_if #(
   parameter int RAM_ADDR_BITS = 5
);
   logic                     mem_read;
   logic                     mem_write;
   logic [1:0]               size;
   logic                     sign_ext;
   logic [31:0]              addr;
   logic [31:0]              wdata;
   logic                     ram_we;
   logic [RAM_ADDR_BITS-1:0] ram_addr;
   logic [31:0]              ram_wdata;
   logic [31:0]              ram_rdata;
   logic [31:0]              load_data;
   logic                     load_valid;
   logic                     stall;
   logic                     misaligned;

   modport master (
      output mem_read, mem_write, size, sign_ext, addr, wdata, ram_rdata,
      input  ram_we, ram_addr, ram_wdata, load_data, load_valid, stall, misaligned
   );

   modport slave (
      input  mem_read, mem_write, size, sign_ext, addr, wdata, ram_rdata,
      output ram_we, ram_addr, ram_wdata, load_data, load_valid, stall, misaligned
   );

endinterface

// File: rtl/mem_access_ctrl_byte_lane_unit.sv
// rtl/mem_access_ctrl_byte_lane_unit.sv - little-endian lane extract and merge for sub-word accesses
// One instance serves both the load path (extract) and the store RMW path (merge).
module byte_lane_unit
   import mem_access_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_sign,
   output logic [31:0] o_extract,
   output logic [31:0] o_merge
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_lane)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
   end

   always_comb begin
      o_extract = i_word;
      case (i_size)
         SZ_BYTE: o_extract = {{24{i_sign & w_byte[7]}}, w_byte};
         SZ_HALF: o_extract = {{16{i_sign & w_half[15]}}, w_half};
         default: o_extract = i_word;
      endcase
   end

   always_comb begin
      o_merge = i_wdata;
      case (i_size)
         SZ_BYTE: begin
            o_merge = i_word;
            case (i_lane)
               2'd0:    o_merge[7:0]   = i_wdata[7:0];
               2'd1:    o_merge[15:8]  = i_wdata[7:0];
               2'd2:    o_merge[23:16] = i_wdata[7:0];
               default: o_merge[31:24] = i_wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            o_merge = i_word;
            if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
            else           o_merge[15:0]  = i_wdata[15:0];
         end
         default: o_merge = i_wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - byte/half/word load-store controller over a single-port synchronous RAM
// Word stores go straight through; loads and sub-word stores take one extra stalled cycle.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int RAM_WIDTH     = 32,
   parameter int RAM_ADDR_BITS = 5
) (
   input  logic               clk,
   input  logic               rst,
   mem_access_ctrl_if.slave   bus
);

   state_t                   r_state;
   state_t                   w_next;
   logic [RAM_ADDR_BITS+1:0] r_addr;
   logic [1:0]               r_size;
   logic                     r_sign;
   logic [RAM_WIDTH-1:0]     r_wdata;

   logic        w_req;
   logic        w_mis;
   logic        w_latch;
   logic [31:0] w_extract;
   logic [31:0] w_merge;
   logic        w_unused;

   assign w_unused = ^bus.addr[31:RAM_ADDR_BITS+2];
   assign w_req    = bus.mem_read | bus.mem_write;
   assign w_mis    = w_req & is_misaligned(bus.size, bus.addr[1:0]);
   assign w_latch  = (r_state == IDLE) & w_req & ~w_mis;

   byte_lane_unit u_lane (
      .i_word    (bus.ram_rdata),
      .i_wdata   (r_wdata),
      .i_lane    (r_addr[1:0]),
      .i_size    (r_size),
      .i_sign    (r_sign),
      .o_extract (w_extract),
      .o_merge   (w_merge)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_size  <= SZ_BYTE;
         r_sign  <= 1'b0;
         r_wdata <= '0;
      end else if (w_latch) begin
         r_addr  <= bus.addr[RAM_ADDR_BITS+1:0];
         r_size  <= bus.size;
         r_sign  <= bus.sign_ext;
         r_wdata <= bus.wdata;
      end
   end

   // Outputs are forced low during reset so an aborted RMW never writes.
   always_comb begin
      w_next         = r_state;
      bus.ram_we     = 1'b0;
      bus.ram_addr   = '0;
      bus.ram_wdata  = '0;
      bus.load_data  = '0;
      bus.load_valid = 1'b0;
      bus.stall      = 1'b0;
      bus.misaligned = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE: begin
               bus.ram_addr = bus.addr[RAM_ADDR_BITS+1:2];
               if (w_req) begin
                  if (w_mis) begin
                     bus.misaligned = 1'b1;
                  end else if (bus.mem_write) begin
                     if (is_subword(bus.size)) begin
                        bus.stall = 1'b1;
                        w_next    = ST_RMW;
                     end else begin
                        bus.ram_we    = 1'b1;
                        bus.ram_wdata = bus.wdata;
                     end
                  end else begin
                     bus.stall = 1'b1;
                     w_next    = LD_WAIT;
                  end
               end
            end
            LD_WAIT: begin
               bus.ram_addr   = r_addr[RAM_ADDR_BITS+1:2];
               bus.load_data  = w_extract;
               bus.load_valid = 1'b1;
               w_next         = IDLE;
            end
            ST_RMW: begin
               bus.ram_addr  = r_addr[RAM_ADDR_BITS+1:2];
               bus.ram_we    = 1'b1;
               bus.ram_wdata = w_merge;
               w_next        = IDLE;
            end
            default: w_next = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl with a behavioural RAM
// Inputs change just after the falling edge; outputs are sampled 2 time units later.
module tb_mem_access_ctrl;
   import mem_access_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] ram [0:31];

   mem_access_ctrl_if #(.RAM_ADDR_BITS(5)) bus_if ();

   mem_access_ctrl #(.RAM_WIDTH(32), .RAM_ADDR_BITS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus_if.ram_we) ram[bus_if.ram_addr] <= bus_if.ram_wdata;
      else               bus_if.ram_rdata     <= ram[bus_if.ram_addr];
   end

   task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd);
      bus_if.mem_read  = rd;
      bus_if.mem_write = wr;
      bus_if.size      = sz;
      bus_if.sign_ext  = sg;
      bus_if.addr      = a;
      bus_if.wdata     = wd;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(1, 1, SZ_WORD, 0, 32'h8, 32'hDEAD);
      #2;
      check("rst_we", {31'd0, bus_if.ram_we}, 0);
      check("rst_stall", {31'd0, bus_if.stall}, 0);
      check("rst_lv", {31'd0, bus_if.load_valid}, 0);
      check("rst_mis", {31'd0, bus_if.misaligned}, 0);
      check("rst_ld", bus_if.load_data, 0);
      check("rst_addr", {27'd0, bus_if.ram_addr}, 0);
      check("rst_wdata", bus_if.ram_wdata, 0);

      next_cycle(); rst = 1'b0; drive(0, 0, SZ_WORD, 0, 0, 0);

      next_cycle(); drive(0, 1, SZ_WORD, 0, 32'h4, 32'h8899AABB); #2;
      check("pre_we", {31'd0, bus_if.ram_we}, 1);
      check("pre_addr", {27'd0, bus_if.ram_addr}, 1);
      check("pre_stall", {31'd0, bus_if.stall}, 0);

      next_cycle(); drive(1, 0, SZ_BYTE, 1, 32'h6, 0); #2;
      check("lbs_stall", {31'd0, bus_if.stall}, 1);
      check("lbs_lv0", {31'd0, bus_if.load_valid}, 0);
      check("lbs_addr", {27'd0, bus_if.ram_addr}, 1);
      next_cycle(); #2;
      check("lbs_lv", {31'd0, bus_if.load_valid}, 1);
      check("lbs_data", bus_if.load_data, 32'hFFFFFF99);
      check("lbs_stall2", {31'd0, bus_if.stall}, 0);

      next_cycle(); drive(1, 0, SZ_BYTE, 0, 32'h6, 0); #2;
      check("lbu_stall", {31'd0, bus_if.stall}, 1);
      next_cycle(); #2;
      check("lbu_data", bus_if.load_data, 32'h00000099);

      next_cycle(); drive(0, 1, SZ_BYTE, 0, 32'h5, 32'h000000CC); #2;
      check("sb_stall", {31'd0, bus_if.stall}, 1);
      check("sb_we0", {31'd0, bus_if.ram_we}, 0);
      next_cycle(); #2;
      check("sb_we", {31'd0, bus_if.ram_we}, 1);
      check("sb_addr", {27'd0, bus_if.ram_addr}, 1);
      check("sb_wdata", bus_if.ram_wdata, 32'h8899CCBB);
      check("sb_stall2", {31'd0, bus_if.stall}, 0);

      next_cycle(); drive(1, 0, SZ_WORD, 0, 32'h4, 0); #2;
      check("lw_stall", {31'd0, bus_if.stall}, 1);
      next_cycle(); #2;
      check("lw_lv", {31'd0, bus_if.load_valid}, 1);
      check("lw_data", bus_if.load_data, 32'h8899CCBB);

      next_cycle(); drive(0, 1, SZ_WORD, 0, 32'h8, 32'hDEADBEEF); #2;
      check("sw_we", {31'd0, bus_if.ram_we}, 1);
      check("sw_addr", {27'd0, bus_if.ram_addr}, 2);
      check("sw_wdata", bus_if.ram_wdata, 32'hDEADBEEF);
      check("sw_stall", {31'd0, bus_if.stall}, 0);

      next_cycle(); drive(1, 0, SZ_HALF, 1, 32'hA, 0); #2;
      check("lh_stall", {31'd0, bus_if.stall}, 1);
      next_cycle(); #2;
      check("lh_data", bus_if.load_data, 32'hFFFFDEAD);

      next_cycle(); drive(1, 0, SZ_HALF, 0, 32'h3, 0); #2;
      check("mlh_mis", {31'd0, bus_if.misaligned}, 1);
      check("mlh_we", {31'd0, bus_if.ram_we}, 0);
      check("mlh_stall", {31'd0, bus_if.stall}, 0);
      next_cycle(); drive(0, 1, SZ_WORD, 0, 32'h6, 32'h11111111); #2;
      check("msw_mis", {31'd0, bus_if.misaligned}, 1);
      check("msw_we", {31'd0, bus_if.ram_we}, 0);
      check("msw_stall", {31'd0, bus_if.stall}, 0);
      next_cycle(); drive(0, 0, SZ_WORD, 0, 0, 0); #2;
      check("mis_clear", {31'd0, bus_if.misaligned}, 0);
      check("ram1_keep", ram[1], 32'h8899CCBB);
      check("ram2_keep", ram[2], 32'hDEADBEEF);

      next_cycle(); drive(0, 1, SZ_BYTE, 0, 32'h4, 32'h00000055); #2;
      check("rsb_stall", {31'd0, bus_if.stall}, 1);
      next_cycle(); #1 rst = 1'b1; #1;
      check("rab_stall", {31'd0, bus_if.stall}, 0);
      check("rab_we", {31'd0, bus_if.ram_we}, 0);
      next_cycle(); rst = 1'b0; drive(0, 0, SZ_WORD, 0, 0, 0); #2;
      check("rab_idle_stall", {31'd0, bus_if.stall}, 0);
      check("rab_idle_we", {31'd0, bus_if.ram_we}, 0);
      check("rab_ram1", ram[1], 32'h8899CCBB);

      next_cycle(); drive(1, 1, SZ_WORD, 0, 32'h8C, 32'h12345678); #2;
      check("rw_we", {31'd0, bus_if.ram_we}, 1);
      check("rw_addr", {27'd0, bus_if.ram_addr}, 3);
      check("rw_wdata", bus_if.ram_wdata, 32'h12345678);
      check("rw_lv", {31'd0, bus_if.load_valid}, 0);
      check("rw_stall", {31'd0, bus_if.stall}, 0);

      next_cycle(); drive(1, 0, 2'b11, 0, 32'hC, 0); #2;
      check("lw3_stall", {31'd0, bus_if.stall}, 1);
      next_cycle(); #2;
      check("lw3_data", bus_if.load_data, 32'h12345678);
      next_cycle(); drive(0, 0, SZ_WORD, 0, 0, 0); #2;
      check("ram3", ram[3], 32'h12345678);
      check("idle_lv", {31'd0, bus_if.load_valid}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
